uart_rx_oversample: RTL and testbench
=====================================

# uart_rx_oversample

Oversampling UART receiver for the 8N1 serial link. It is the receiving end for the team's UART transmitter and replaces single-sample reception where line noise or clock skew matters. Each bit is sampled 16 times, and the bit value is decided by a 3-sample majority vote at mid-bit. The block rejects glitches on the start bit, flags framing errors and overruns, and hands received bytes to the system side over a valid/ready handshake.

## Interface
- SYS_CLK_RATE, 50000000, system clock frequency in Hz
- BAUD_RATE, 9600, baud rate used after reset
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- rx  input  1  asynchronous serial line; idle high
- clk_speed_sel  input  4  one-hot baud select: 4'b1000=9600, 4'b0100=56000, 4'b0010=115200; all other codes keep the current rate
- rx_data  output  8  received byte; stable while rx_valid is high
- rx_valid  output  1  byte available; held until accepted
- rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready
- rx_busy  output  1  high while a frame is in progress (state != IDLE)
- rx_frame_err  output  1  one-cycle pulse when the stop bit is sampled low
- rx_overrun  output  1  one-cycle pulse when a completed byte is dropped

## Operation
- **Synchronizer:** rx passes through 2 flip-flops, reset value 1. All decisions use the synchronized rx_s.
- **Divider:**
  - div = SYS_CLK_RATE/(16*baud), integer truncation: 325 / 55 / 27 for the three rates.
  - Reset value is SYS_CLK_RATE/(16*BAUD_RATE).
  - A new clk_speed_sel value is latched only while in IDLE.
- **Tick counter:**
  - 16-bit counter counts 0..div-1. The tick pulse occurs on the cycle the count equals div-1, and the counter then returns to 0.
  - While in IDLE the counter is held at 0 until a start is detected, so bit timing aligns to the start edge.
- **Oversample counter:** os_cnt, 4 bits, increments on each tick and wraps 15 -> 0.
  - Samples are captured at os_cnt 7, 8 and 9.
  - Bit value = majority of the three samples, evaluated on the tick where os_cnt==9.
- **States:** IDLE, START, DATA, STOP.
  - **IDLE:**
    - The armed flag sets when rx_s==1.
    - If armed and rx_s==0: go to START, set os_cnt=0, start the tick counter.
  - **START:**
    - At os 9: if majority==1, treat it as a false start and return to IDLE, with no output and no error.
    - Otherwise, at os 15 go to DATA with bit_idx=0.
  - **DATA:**
    - At os 9, shift the majority bit in LSB-first, i.e. shifter <= {bit, shifter[7:1]}.
    - At os 15: bit_idx++. After bit_idx 7 completes, go to STOP.
  - **STOP:** at os 9:
    - Majority 1: deliver the byte (see below) and go to IDLE.
    - Majority 0: pulse rx_frame_err, discard the byte, clear armed, and go to IDLE.
    - Returning to IDLE at mid-stop allows a back-to-back start bit to be detected.
- **Deliver:**
  - If rx_valid==0, or rx_valid && rx_ready on this same cycle: load rx_data and set rx_valid.
  - Otherwise pulse rx_overrun and keep the old rx_data.
- **Handshake:**
  - rx_valid clears on the cycle after rx_valid && rx_ready, unless a new byte is loaded on that same edge.
  - rx_data only changes on a load.
- **Reset mid-frame:** the frame is abandoned and nothing is delivered.
- **Reset values:**
  - Outputs: rx_data=0, rx_valid=0, rx_busy=0, rx_frame_err=0, rx_overrun=0.
  - Internal: state=IDLE, armed=0, rx_s=1.

## Timing
- Start detection occurs on the first clk with rx_s==0 in IDLE, 2–3 clk after the line edge.
- Stop decision occurs on tick number 9*16+10 = 154 after start detection. Each tick is div clk.
- rx_valid rises 1 clk after the stop decision tick.
- rx_frame_err and rx_overrun are asserted for exactly 1 clk, on the same cycle rx_valid would have loaded.
- rx_busy rises the clk after start detection and falls the clk after the stop decision or a false-start reject.
- Tolerates ±3% cumulative baud mismatch, since the mid-bit window is about ±7/16 bit.

## Test plan
- **Basic receive:** at reset rate 9600, drive frame 0xA5 with bit time 5208 clk, rx_ready=1.
  - Required: rx_valid pulses for 1 clk with rx_data=0xA5, no error pulses.
- **Glitch rejection:** drive rx low for 2000 clk (less than half a bit), then idle.
  - Required: rx_busy rises then falls, rx_valid stays 0, no rx_frame_err.
- **Framing error:** at 115200 (clk_speed_sel=4'b0010, bit time 434 clk), send 0x3C with stop bit low, then hold the line low for 2 bits.
  - Required: one rx_frame_err pulse, no rx_valid, and no new start detected until the line returns high.
- **Overrun:** rx_ready=0, send 0x11 then 0x22 back-to-back.
  - Required: rx_data stays 0x11 with rx_valid high, and one rx_overrun pulse at the second stop.
  - Raise rx_ready: rx_valid falls after 1 clk.
- **Noise and skew:** at 56000, send 0x5A with bit time +3% and a 1-clk inverted spike at the mid-bit of each bit.
  - Required: rx_data=0x5A, no errors.
- **Reset mid-frame:** assert rst for 1 clk during bit 4 of 0xFF, then send 0x81.
  - Required: only 0x81 is delivered, and all outputs are at their reset values on the clk after rst.

Source files
------------

// File: rtl/uart_rx_oversample.sv
// Purpose: 8N1 UART receiver, 16x oversampled, 3-sample mid-bit majority vote.
// Latency: byte presented on rx_data/rx_valid 1 clk after the mid-stop-bit decision tick.
// Backpressure: rx_valid held until rx_ready; a byte completing while still held is dropped (rx_overrun).
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   rx              asynchronous serial line (idle high)
//   clk_speed_sel   one-hot baud select (1000=9600, 0100=56000, 0010=115200), latched in IDLE only
//   rx_data/rx_valid/rx_ready   received byte with valid/ready handshake
//   rx_busy         frame in progress
//   rx_frame_err    1-clk pulse: stop bit sampled low
//   rx_overrun      1-clk pulse: completed byte dropped
module uart_rx_oversample #(
    parameter int unsigned SYS_CLK_RATE = 50000000,
    parameter int unsigned BAUD_RATE    = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic [3:0] clk_speed_sel,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_busy,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam logic [15:0] DIV_RESET  = 16'(SYS_CLK_RATE / (16 * BAUD_RATE));
    localparam logic [15:0] DIV_9600   = 16'(SYS_CLK_RATE / (16 * 9600));
    localparam logic [15:0] DIV_56000  = 16'(SYS_CLK_RATE / (16 * 56000));
    localparam logic [15:0] DIV_115200 = 16'(SYS_CLK_RATE / (16 * 115200));

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_s_q;
    logic [15:0] div_q, div_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  os_q, os_d;
    logic [1:0]  samp_q, samp_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        armed_q, armed_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;
    logic        tick;
    logic        maj;
    logic        load;

    // Counter only runs outside IDLE, so bit timing is anchored to the start edge.
    assign tick = (state_q != IDLE) && (cnt_q == (div_q - 16'd1));

    // Samples from os 7 and 8 are stored; the os 9 sample is the live line value.
    assign maj = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_s_q) | (samp_q[0] & rx_s_q);

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        os_d        = os_q;
        samp_d      = samp_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        armed_d     = armed_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        load        = 1'b0;

        if (state_q == IDLE || tick) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end

        if (tick) begin
            os_d = os_q + 4'd1;
            if (os_q == 4'd7) samp_d[0] = rx_s_q;
            if (os_q == 4'd8) samp_d[1] = rx_s_q;
        end

        case (state_q)
            IDLE: begin
                case (clk_speed_sel)
                    4'b1000: div_d = DIV_9600;
                    4'b0100: div_d = DIV_56000;
                    4'b0010: div_d = DIV_115200;
                    default: ;
                endcase
                // Armed only after seeing the line high, so a line stuck low
                // after a framing error cannot retrigger.
                if (rx_s_q) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = START;
                    os_d    = 4'd0;
                end
            end
            START: begin
                if (tick) begin
                    if (os_q == 4'd9 && maj) begin
                        state_d = IDLE;
                    end else if (os_q == 4'd15) begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (os_q == 4'd9) shift_d = {maj, shift_q[7:1]};
                    if (os_q == 4'd15) begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) state_d = STOP;
                    end
                end
            end
            STOP: begin
                // Leave at mid-stop so a back-to-back start edge is caught.
                if (tick && os_q == 4'd9) begin
                    state_d = IDLE;
                    if (maj) begin
                        if (!rx_valid_q || rx_ready) begin
                            load = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        armed_d     = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            div_q       <= DIV_RESET;
            cnt_q       <= 16'd0;
            os_q        <= 4'd0;
            samp_q      <= 2'b11;
            shift_q     <= 8'd0;
            bit_idx_q   <= 3'd0;
            armed_q     <= 1'b0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            os_q        <= os_d;
            samp_q      <= samp_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            armed_q     <= armed_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_busy      = (state_q != IDLE);
    assign rx_frame_err = frame_err_q;
    assign rx_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample: scoreboard queue of expected bytes,
// popped whenever the DUT hands a byte over (rx_valid && rx_ready).
// Inputs change on negedge; the monitor samples 1 time unit after negedge.
module tb_uart_rx_oversample;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [3:0] clk_speed_sel;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_busy;
    logic       rx_frame_err;
    logic       rx_overrun;

    uart_rx_oversample #(
        .SYS_CLK_RATE(50000000),
        .BAUD_RATE   (9600)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .clk_speed_sel(clk_speed_sel),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_busy      (rx_busy),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] sb_q[$];

    // Event counters maintained by the monitor.
    int valid_cyc = 0;
    int ferr_cnt  = 0;
    int ovr_cnt   = 0;
    int busy_rise = 0;
    logic busy_prev = 1'b0;

    // Snapshots taken by the directed sequence.
    int s_valid, s_ferr, s_ovr, s_rise;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_valid = valid_cyc;
        s_ferr  = ferr_cnt;
        s_ovr   = ovr_cnt;
        s_rise  = busy_rise;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 frame; optional 1-clk inverted spike at the middle of every bit.
    task automatic send_frame(input logic [7:0] b, input int bt, input logic stop_v, input bit spike);
        logic v;
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      v = 1'b0;
            else if (i == 9) v = stop_v;
            else             v = b[i-1];
            rx = v;
            if (spike) begin
                repeat (bt / 2) @(negedge clk);
                rx = ~v;
                @(negedge clk);
                rx = v;
                repeat (bt - bt / 2 - 1) @(negedge clk);
            end else begin
                repeat (bt) @(negedge clk);
            end
        end
        rx = 1'b1;
    endtask

    task automatic set_rate(input logic [3:0] sel);
        clk_speed_sel = sel;
        wait_clk(2);
        clk_speed_sel = 4'b0000;
        wait_clk(2);
    endtask

    // Monitor: handshake acceptance pops the scoreboard; pulses are counted.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (rx_valid && rx_ready) begin
                check("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) check("rx_data_accept", 32'(rx_data), 32'(sb_q.pop_front()));
            end
            if (rx_valid)     valid_cyc++;
            if (rx_frame_err) ferr_cnt++;
            if (rx_overrun)   ovr_cnt++;
            if (rx_busy && !busy_prev) busy_rise++;
        end
        busy_prev = rx_busy;
    end

    initial begin
        rst           = 1'b1;
        rx            = 1'b1;
        rx_ready      = 1'b1;
        clk_speed_sel = 4'b0000;
        wait_clk(5);

        // Reset state
        check("rst_rx_data",  32'(rx_data),      32'd0);
        check("rst_rx_valid", 32'(rx_valid),     32'd0);
        check("rst_rx_busy",  32'(rx_busy),      32'd0);
        check("rst_ferr",     32'(rx_frame_err), 32'd0);
        check("rst_ovr",      32'(rx_overrun),   32'd0);
        rst = 1'b0;
        wait_clk(20);

        // Basic receive at 9600 (reset rate)
        snap();
        sb_q.push_back(8'hA5);
        send_frame(8'hA5, 5208, 1'b1, 1'b0);
        wait_clk(20);
        check("basic_sb_empty",   32'(sb_q.size()),      32'd0);
        check("basic_valid_1clk", 32'(valid_cyc - s_valid), 32'd1);
        check("basic_rx_data",    32'(rx_data),          32'hA5);
        check("basic_no_ferr",    32'(ferr_cnt - s_ferr), 32'd0);
        check("basic_no_ovr",     32'(ovr_cnt - s_ovr),   32'd0);

        // Glitch rejection at 115200: low for 150 clk (< half of a 434-clk bit)
        set_rate(4'b0010);
        snap();
        rx = 1'b0;
        wait_clk(10);
        check("glitch_busy_hi", 32'(rx_busy), 32'd1);
        wait_clk(140);
        rx = 1'b1;
        wait_clk(400);
        check("glitch_busy_lo",  32'(rx_busy),            32'd0);
        check("glitch_no_valid", 32'(valid_cyc - s_valid), 32'd0);
        check("glitch_no_ferr",  32'(ferr_cnt - s_ferr),  32'd0);

        // Framing error: stop bit low, line then held low for two more bits
        snap();
        send_frame(8'h3C, 434, 1'b0, 1'b0);
        rx = 1'b0;
        s_rise = busy_rise;
        wait_clk(868);
        check("ferr_one_pulse",  32'(ferr_cnt - s_ferr),   32'd1);
        check("ferr_no_valid",   32'(valid_cyc - s_valid), 32'd0);
        check("ferr_no_restart", 32'(busy_rise - s_rise),  32'd0);
        check("ferr_busy_lo",    32'(rx_busy),             32'd0);
        rx = 1'b1;
        wait_clk(434);

        // Overrun: consumer stalled, two back-to-back frames
        rx_ready = 1'b0;
        snap();
        sb_q.push_back(8'h11);
        send_frame(8'h11, 434, 1'b1, 1'b0);
        send_frame(8'h22, 434, 1'b1, 1'b0);
        wait_clk(10);
        check("ovr_valid_held", 32'(rx_valid),          32'd1);
        check("ovr_data_kept",  32'(rx_data),           32'h11);
        check("ovr_one_pulse",  32'(ovr_cnt - s_ovr),   32'd1);
        check("ovr_no_ferr",    32'(ferr_cnt - s_ferr), 32'd0);
        rx_ready = 1'b1;
        wait_clk(1);
        check("ovr_valid_drop", 32'(rx_valid),     32'd0);
        check("ovr_sb_empty",   32'(sb_q.size()), 32'd0);

        // Noise and skew at 56000: bit time +3%, spike mid-bit
        set_rate(4'b0100);
        snap();
        sb_q.push_back(8'h5A);
        send_frame(8'h5A, 920, 1'b1, 1'b1);
        wait_clk(20);
        check("noise_sb_empty", 32'(sb_q.size()),        32'd0);
        check("noise_rx_data",  32'(rx_data),            32'h5A);
        check("noise_no_ferr",  32'(ferr_cnt - s_ferr),  32'd0);
        check("noise_no_ovr",   32'(ovr_cnt - s_ovr),    32'd0);

        // Reset during bit 4 of 0xFF, then a clean 0x81
        set_rate(4'b0010);
        rx = 1'b0;
        wait_clk(434);
        rx = 1'b1;
        wait_clk(4 * 434 + 200);
        check("rstmid_busy_before", 32'(rx_busy), 32'd1);
        rst = 1'b1;
        wait_clk(1);
        check("rstmid_rx_data",  32'(rx_data),      32'd0);
        check("rstmid_rx_valid", 32'(rx_valid),     32'd0);
        check("rstmid_rx_busy",  32'(rx_busy),      32'd0);
        check("rstmid_ferr",     32'(rx_frame_err), 32'd0);
        check("rstmid_ovr",      32'(rx_overrun),   32'd0);
        rst = 1'b0;
        wait_clk(2000);
        set_rate(4'b0010);
        snap();
        sb_q.push_back(8'h81);
        send_frame(8'h81, 434, 1'b1, 1'b0);
        wait_clk(20);
        check("rstmid_sb_empty", 32'(sb_q.size()),          32'd0);
        check("rstmid_one_byte", 32'(valid_cyc - s_valid),  32'd1);
        check("rstmid_rx_data2", 32'(rx_data),              32'h81);
        check("rstmid_no_ferr",  32'(ferr_cnt - s_ferr),    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
